// File: rtl/conv_operand_streamer_if.sv
// Signal bundle between the operand streamer, its two source memories and the device load port.
// master = streamer side, slave = memory/device side.
interface conv_operand_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int A_ADDR_W   = 14,
    parameter int B_ADDR_W   = 11
);
    logic                  start;
    logic                  busy;
    logic                  done;

    logic                  a_src_re;
    logic [A_ADDR_W-1:0]   a_src_addr;
    logic [DATA_WIDTH-1:0] a_src_rdata;
    logic                  b_src_re;
    logic [B_ADDR_W-1:0]   b_src_addr;
    logic [DATA_WIDTH-1:0] b_src_rdata;

    logic                  a_valid;
    logic                  a_ready;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [DATA_WIDTH-1:0] b_data;

    modport master (
        input  start, a_src_rdata, b_src_rdata, a_ready, b_ready,
        output busy, done, a_src_re, a_src_addr, b_src_re, b_src_addr,
               a_valid, a_data, b_valid, b_data
    );

    modport slave (
        output start, a_src_rdata, b_src_rdata, a_ready, b_ready,
        input  busy, done, a_src_re, a_src_addr, b_src_re, b_src_addr,
               a_valid, a_data, b_valid, b_data
    );
endinterface

// File: rtl/conv_operand_streamer.sv
// Streams the activation image and then the weight set from two 1-cycle-latency source
// memories to the convolution device over valid/ready handshakes, with a done pulse at the end.
module conv_operand_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int A_WORDS    = 16384,
    parameter int B_WORDS    = 1152,
    parameter int A_ADDR_W   = 14,
    parameter int B_ADDR_W   = 11
) (
    input  logic clk,
    input  logic arst_in,
    conv_operand_streamer_if.master bus
);
    // state  | meaning
    // IDLE   | waiting for start
    // SEND_A | reading and streaming activation words
    // SEND_B | reading and streaming weight words
    // DONE   | single-cycle completion pulse
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    // One spare counter bit so a word count equal to 2^ADDR_W does not wrap.
    localparam int A_CW = A_ADDR_W + 1;
    localparam int B_CW = B_ADDR_W + 1;
    localparam logic [A_CW-1:0] A_COUNT = A_CW'(A_WORDS);
    localparam logic [A_CW-1:0] A_LAST  = A_CW'(A_WORDS - 1);
    localparam logic [B_CW-1:0] B_COUNT = B_CW'(B_WORDS);
    localparam logic [B_CW-1:0] B_LAST  = B_CW'(B_WORDS - 1);

    state_t state;
    logic   busy_q;
    logic   done_q;
    logic   enter_a;

    logic [A_CW-1:0]       a_issue;
    logic [A_CW-1:0]       a_sent;
    logic                  a_inflight;
    logic [DATA_WIDTH-1:0] a_mem [2];
    logic                  a_wr_ptr;
    logic                  a_rd_ptr;
    logic [1:0]            a_cnt;
    logic [2:0]            a_level;
    logic                  a_re;
    logic                  a_pop;

    logic [B_CW-1:0]       b_issue;
    logic [B_CW-1:0]       b_sent;
    logic                  b_inflight;
    logic [DATA_WIDTH-1:0] b_mem [2];
    logic                  b_wr_ptr;
    logic                  b_rd_ptr;
    logic [1:0]            b_cnt;
    logic [2:0]            b_level;
    logic                  b_re;
    logic                  b_pop;

    assign enter_a = (state == IDLE) && bus.start;

    // Room check counts buffered words plus the read still in flight, crediting a pop this cycle.
    assign a_pop   = (a_cnt != 2'd0) && bus.a_ready;
    assign a_level = 3'(a_cnt) + 3'(a_inflight) - 3'(a_pop);
    assign a_re    = (state == SEND_A) && (a_issue < A_COUNT) && (a_level < 3'd2);

    assign b_pop   = (b_cnt != 2'd0) && bus.b_ready;
    assign b_level = 3'(b_cnt) + 3'(b_inflight) - 3'(b_pop);
    assign b_re    = (state == SEND_B) && (b_issue < B_COUNT) && (b_level < 3'd2);

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.a_src_re   = a_re;
    assign bus.a_src_addr = a_issue[A_ADDR_W-1:0];
    assign bus.b_src_re   = b_re;
    assign bus.b_src_addr = b_issue[B_ADDR_W-1:0];
    assign bus.a_valid    = (a_cnt != 2'd0);
    assign bus.a_data     = a_mem[a_rd_ptr];
    assign bus.b_valid    = (b_cnt != 2'd0);
    assign bus.b_data     = b_mem[b_rd_ptr];

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SEND_A;
                        busy_q <= 1'b1;
                    end
                end
                SEND_A: begin
                    if (a_pop && (a_sent == A_LAST)) begin
                        state <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (b_pop && (b_sent == B_LAST)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            a_issue    <= '0;
            a_sent     <= '0;
            a_inflight <= 1'b0;
            b_issue    <= '0;
            b_sent     <= '0;
            b_inflight <= 1'b0;
        end else begin
            if (enter_a) begin
                a_issue <= '0;
                a_sent  <= '0;
                b_issue <= '0;
                b_sent  <= '0;
            end else begin
                if (a_re)  a_issue <= a_issue + 1'b1;
                if (a_pop) a_sent  <= a_sent + 1'b1;
                if (b_re)  b_issue <= b_issue + 1'b1;
                if (b_pop) b_sent  <= b_sent + 1'b1;
            end
            a_inflight <= a_re;
            b_inflight <= b_re;
        end
    end

    // Two-entry buffers; the word read last cycle is captured straight from the source data bus.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            a_mem[0] <= '0;
            a_mem[1] <= '0;
            a_wr_ptr <= 1'b0;
            a_rd_ptr <= 1'b0;
            a_cnt    <= 2'd0;
        end else begin
            if (a_inflight) begin
                a_mem[a_wr_ptr] <= bus.a_src_rdata;
                a_wr_ptr        <= ~a_wr_ptr;
            end
            if (a_pop) begin
                a_rd_ptr <= ~a_rd_ptr;
            end
            a_cnt <= a_cnt + 2'(a_inflight) - 2'(a_pop);
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            b_mem[0] <= '0;
            b_mem[1] <= '0;
            b_wr_ptr <= 1'b0;
            b_rd_ptr <= 1'b0;
            b_cnt    <= 2'd0;
        end else begin
            if (b_inflight) begin
                b_mem[b_wr_ptr] <= bus.b_src_rdata;
                b_wr_ptr        <= ~b_wr_ptr;
            end
            if (b_pop) begin
                b_rd_ptr <= ~b_rd_ptr;
            end
            b_cnt <= b_cnt + 2'(b_inflight) - 2'(b_pop);
        end
    end

endmodule

// File: tb/tb_conv_operand_streamer.sv
// Scoreboard bench for conv_operand_streamer: a small 8/4-word instance for timing, backpressure
// and reset cases, plus a default-size instance for full-length streaming.
module tb_conv_operand_streamer;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int BW    = 4;
    localparam int AAW   = 3;
    localparam int BAW   = 2;
    localparam int BIG_A = 16384;
    localparam int BIG_B = 1152;

    logic clk      = 1'b0;
    logic arst_in  = 1'b1;
    logic arst_big = 1'b1;
    int   cyc      = 0;
    int   n_vec    = 0;
    int   n_err    = 0;
    int   rdy_mode = 0;
    int   ph       = 0;
    int   t0       = 0;

    logic [DW-1:0] a_q[$];
    logic [DW-1:0] b_q[$];
    int   a_next   = 0;
    int   b_next   = 0;
    int   a_xfer   = 0;
    int   done_cnt = 0;
    int   a_out    = 0;
    int   b_out    = 0;

    int   big_on       = 0;
    int   big_t0       = 0;
    int   big_a_reads  = 0;
    int   big_b_reads  = 0;
    int   big_a_xf     = 0;
    int   big_b_xf     = 0;
    int   big_last_a   = -1;
    int   big_last_b   = -1;
    int   big_bad      = 0;
    int   big_done_rel = -1;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_operand_streamer_if #(.DATA_WIDTH(DW), .A_ADDR_W(AAW), .B_ADDR_W(BAW)) sif ();
    conv_operand_streamer #(
        .DATA_WIDTH(DW), .A_WORDS(AW), .B_WORDS(BW), .A_ADDR_W(AAW), .B_ADDR_W(BAW)
    ) dut (
        .clk(clk),
        .arst_in(arst_in),
        .bus(sif)
    );

    conv_operand_streamer_if #(.DATA_WIDTH(16), .A_ADDR_W(14), .B_ADDR_W(11)) bif ();
    conv_operand_streamer dut_big (
        .clk(clk),
        .arst_in(arst_big),
        .bus(bif)
    );

    // Source memories: data = address + 100, one cycle after the read enable.
    always @(posedge clk) begin
        if (sif.a_src_re) sif.a_src_rdata <= 16'(sif.a_src_addr) + 16'd100;
        if (sif.b_src_re) sif.b_src_rdata <= 16'(sif.b_src_addr) + 16'd100;
        if (bif.a_src_re) bif.a_src_rdata <= 16'(bif.a_src_addr) + 16'd100;
        if (bif.b_src_re) bif.b_src_rdata <= 16'(bif.b_src_addr) + 16'd100;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},   64'(sif.busy),       64'(0));
        chk({tag, "_done"},   64'(sif.done),       64'(0));
        chk({tag, "_a_re"},   64'(sif.a_src_re),   64'(0));
        chk({tag, "_a_addr"}, 64'(sif.a_src_addr), 64'(0));
        chk({tag, "_b_re"},   64'(sif.b_src_re),   64'(0));
        chk({tag, "_b_addr"}, 64'(sif.b_src_addr), 64'(0));
        chk({tag, "_a_vld"},  64'(sif.a_valid),    64'(0));
        chk({tag, "_b_vld"},  64'(sif.b_valid),    64'(0));
        chk({tag, "_a_data"}, 64'(sif.a_data),     64'(0));
        chk({tag, "_b_data"}, 64'(sif.b_data),     64'(0));
    endtask

    task automatic run_start();
        @(posedge clk); #2;
        sif.start = 1'b1;
        for (int i = 0; i < AW; i++) a_q.push_back(16'(i + 100));
        for (int i = 0; i < BW; i++) b_q.push_back(16'(i + 100));
        a_next   = 0;
        b_next   = 0;
        a_xfer   = 0;
        done_cnt = 0;
        @(posedge clk); #2;
        sif.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic pulse_start();
        @(posedge clk); #2;
        sif.start = 1'b1;
        @(posedge clk); #2;
        sif.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!sif.done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!sif.done) chk(tag, 64'(0), 64'(1));
    endtask

    task automatic finish_run(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_done_cnt"}, 64'(done_cnt),   64'(1));
        chk({tag, "_a_left"},   64'(a_q.size()), 64'(0));
        chk({tag, "_b_left"},   64'(b_q.size()), 64'(0));
        chk({tag, "_busy_end"}, 64'(sif.busy),   64'(0));
    endtask

    // Ready driver: changes just after each rising edge.
    initial begin
        sif.a_ready = 1'b1;
        sif.b_ready = 1'b1;
        bif.a_ready = 1'b1;
        bif.b_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            ph++;
            if (rdy_mode == 0) begin
                sif.a_ready = 1'b1;
                sif.b_ready = 1'b1;
            end else begin
                sif.a_ready = (ph % 3 == 0);
                sif.b_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Small-instance monitor: scoreboard, stall stability, read credit and phase isolation.
    initial begin
        logic          a_stall;
        logic          b_stall;
        logic [DW-1:0] a_hold;
        logic [DW-1:0] b_hold;
        logic [DW-1:0] exp_d;
        logic          a_pop_n;
        logic          b_pop_n;
        a_stall = 1'b0;
        b_stall = 1'b0;
        a_hold  = '0;
        b_hold  = '0;
        forever begin
            @(negedge clk);
            if (arst_in) begin
                a_stall = 1'b0;
                b_stall = 1'b0;
                a_out   = 0;
                b_out   = 0;
                continue;
            end
            a_pop_n = sif.a_valid && sif.a_ready;
            b_pop_n = sif.b_valid && sif.b_ready;
            if (a_stall) begin
                chk("a_hold_valid", 64'(sif.a_valid), 64'(1));
                chk("a_hold_data",  64'(sif.a_data),  64'(a_hold));
            end
            if (b_stall) begin
                chk("b_hold_valid", 64'(sif.b_valid), 64'(1));
                chk("b_hold_data",  64'(sif.b_data),  64'(b_hold));
            end
            if (a_pop_n) begin
                if (a_q.size() == 0) chk("a_extra_word", 64'(sif.a_data), 64'(0));
                else begin
                    exp_d = a_q.pop_front();
                    chk("a_data", 64'(sif.a_data), 64'(exp_d));
                end
                a_xfer++;
            end
            if (b_pop_n) begin
                if (b_q.size() == 0) chk("b_extra_word", 64'(sif.b_data), 64'(0));
                else begin
                    exp_d = b_q.pop_front();
                    chk("b_data", 64'(sif.b_data), 64'(exp_d));
                end
            end
            if (sif.a_src_re) begin
                chk("a_re_credit", 64'((a_out - int'(a_pop_n)) < 2), 64'(1));
                chk("a_src_addr",  64'(sif.a_src_addr), 64'(a_next));
                a_next++;
            end
            if (sif.b_src_re) begin
                chk("b_re_credit", 64'((b_out - int'(b_pop_n)) < 2), 64'(1));
                chk("b_src_addr",  64'(sif.b_src_addr), 64'(b_next));
                b_next++;
            end
            if (sif.a_src_re || sif.a_valid)
                chk("b_in_a_phase", 64'(sif.b_src_re || sif.b_valid), 64'(0));
            if (sif.b_src_re || sif.b_valid)
                chk("a_in_b_phase", 64'(sif.a_src_re || sif.a_valid), 64'(0));
            a_out   = a_out + int'(sif.a_src_re) - int'(a_pop_n);
            b_out   = b_out + int'(sif.b_src_re) - int'(b_pop_n);
            a_stall = sif.a_valid && !sif.a_ready;
            b_stall = sif.b_valid && !sif.b_ready;
            a_hold  = sif.a_data;
            b_hold  = sif.b_data;
            if (sif.done) done_cnt++;
        end
    end

    // Default-size instance monitor: accumulates counts, checked once at the end.
    initial begin
        forever begin
            @(negedge clk);
            if (!arst_big && big_on != 0) begin
                if (bif.a_src_re) begin
                    if (int'(bif.a_src_addr) != big_a_reads) big_bad++;
                    big_last_a = int'(bif.a_src_addr);
                    big_a_reads++;
                end
                if (bif.b_src_re) begin
                    if (int'(bif.b_src_addr) != big_b_reads) big_bad++;
                    big_last_b = int'(bif.b_src_addr);
                    big_b_reads++;
                end
                if (bif.a_valid && bif.a_ready) begin
                    if (bif.a_data != 16'(big_a_xf + 100)) big_bad++;
                    big_a_xf++;
                end
                if (bif.b_valid && bif.b_ready) begin
                    if (bif.b_data != 16'(big_b_xf + 100)) big_bad++;
                    big_b_xf++;
                end
                if (bif.a_valid && bif.b_valid) big_bad++;
                if (bif.done && big_done_rel < 0) big_done_rel = cyc - big_t0;
            end
        end
    end

    initial begin
        int k;
        sif.start = 1'b0;
        bif.start = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        arst_in  = 1'b0;
        arst_big = 1'b0;
        @(negedge clk);
        check_idle("released");

        // Full-speed streaming with exact cycle positions.
        rdy_mode = 0;
        run_start();
        for (int r = 0; r <= 18; r++) begin
            @(negedge clk);
            chk("fs_a_re",    64'(sif.a_src_re), 64'(r <= 7));
            chk("fs_a_valid", 64'(sif.a_valid),  64'(r >= 2 && r <= 9));
            chk("fs_b_re",    64'(sif.b_src_re), 64'(r >= 10 && r <= 13));
            chk("fs_b_valid", 64'(sif.b_valid),  64'(r >= 12 && r <= 15));
            chk("fs_done",    64'(sif.done),     64'(r == 16));
            chk("fs_busy",    64'(sif.busy),     64'(r <= 16));
        end
        finish_run("fs");

        // Backpressure with start pulses during both phases.
        rdy_mode = 1;
        run_start();
        repeat (4) @(negedge clk);
        chk("ign_busy_a", 64'(sif.busy), 64'(1));
        pulse_start();
        k = 0;
        while (b_q.size() == BW && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("ign_reach_b", 64'(b_q.size() < BW), 64'(1));
        pulse_start();
        wait_done("ign_done_timeout", 300);
        finish_run("ign");

        // Reset mid-SEND_A after three activation transfers, then a clean restart.
        rdy_mode = 0;
        run_start();
        k = 0;
        while (a_xfer < 3 && k < 50) begin
            @(posedge clk); #3;
            k++;
        end
        chk("mid_rst_xfers", 64'(a_xfer), 64'(3));
        #1;
        arst_in = 1'b1;
        #1;
        check_idle("mid_rst");
        a_q.delete();
        b_q.delete();
        repeat (2) @(negedge clk);
        arst_in = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("mid_rst_idle");
        run_start();
        wait_done("restart_done_timeout", 100);
        finish_run("restart");

        // Default-size streaming.
        @(posedge clk); #2;
        bif.start = 1'b1;
        @(posedge clk); #2;
        bif.start = 1'b0;
        big_t0 = cyc;
        big_on = 1;
        k = 0;
        while (big_done_rel < 0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk("big_done_cycle", 64'(big_done_rel), 64'(BIG_A + BIG_B + 4));
        chk("big_a_xfers",    64'(big_a_xf),     64'(BIG_A));
        chk("big_b_xfers",    64'(big_b_xf),     64'(BIG_B));
        chk("big_a_reads",    64'(big_a_reads),  64'(BIG_A));
        chk("big_b_reads",    64'(big_b_reads),  64'(BIG_B));
        chk("big_last_a",     64'(big_last_a),   64'(BIG_A - 1));
        chk("big_last_b",     64'(big_last_b),   64'(BIG_B - 1));
        chk("big_order",      64'(big_bad),      64'(0));
        chk("big_busy_end",   64'(bif.busy),     64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
